mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester channels plus the shared memory port.
//   slave  : the arbiter's view (takes requests and mem_ack, drives grants, done/err and the memory port)
//   master : the environment's view (drives requests and mem_ack, observes everything else)
interface mem_port_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Requester side
    logic              req_0;
    logic              req_1;
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_0;
    logic [DATA_W-1:0] wdata_1;
    logic              we_0;
    logic              we_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              done_0;
    logic              done_1;
    logic              err;

    // Memory side
    logic              sel;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ack;

    modport slave (
        input  req_0, req_1, addr_0, addr_1, wdata_0, wdata_1, we_0, we_1, mem_ack,
        output gnt_0, gnt_1, done_0, done_1, err, sel, mem_req, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_0, req_1, addr_0, addr_1, wdata_0, wdata_1, we_0, we_1, mem_ack,
        input  gnt_0, gnt_1, done_0, done_1, err, sel, mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single memory port with a per-access timeout.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave -- requests/addr/wdata/we from two requesters,
//            registered gnt/done/err/sel/mem_req, mem_addr/mem_wdata/mem_we muxed by sel,
//            mem_ack from memory
// A transaction runs IDLE -> BUSY -> DONE -> IDLE; BUSY ends on mem_ack or after TIMEOUT
// cycles without it (err=1 alongside the done pulse).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_grant_q;
    logic             last_grant_d;
    logic             sel_d;
    logic             gnt_0_d;
    logic             gnt_1_d;
    logic             done_0_d;
    logic             done_1_d;
    logic             err_d;
    logic             mem_req_d;
    logic             winner_c;

    // Lone requester wins; on a tie the one not granted last time wins
    assign winner_c = (bus.req_0 && bus.req_1) ? ~last_grant_q : bus.req_1;

    // Memory-side data path follows the registered select
    assign bus.mem_addr  = bus.sel ? bus.addr_1  : bus.addr_0;
    assign bus.mem_wdata = bus.sel ? bus.wdata_1 : bus.wdata_0;
    assign bus.mem_we    = bus.mem_req & (bus.sel ? bus.we_1 : bus.we_0);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_d        = bus.sel;
        gnt_0_d      = 1'b0;
        gnt_1_d      = 1'b0;
        done_0_d     = 1'b0;
        done_1_d     = 1'b0;
        err_d        = 1'b0;
        mem_req_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_0 || bus.req_1) begin
                    state_d      = BUSY;
                    sel_d        = winner_c;
                    last_grant_d = winner_c;
                    gnt_0_d      = ~winner_c;
                    gnt_1_d      = winner_c;
                    mem_req_d    = 1'b1;
                    cnt_d        = '0;
                end
            end
            BUSY: begin
                // mem_ack outranks a timeout landing on the same cycle
                if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d  = DONE;
                    done_0_d = ~bus.sel;
                    done_1_d = bus.sel;
                    err_d    = ~bus.mem_ack;
                    cnt_d    = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                    gnt_0_d   = ~bus.sel;
                    gnt_1_d   = bus.sel;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            bus.sel      <= 1'b0;
            bus.gnt_0    <= 1'b0;
            bus.gnt_1    <= 1'b0;
            bus.done_0   <= 1'b0;
            bus.done_1   <= 1'b0;
            bus.err      <= 1'b0;
            bus.mem_req  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            bus.sel      <= sel_d;
            bus.gnt_0    <= gnt_0_d;
            bus.gnt_1    <= gnt_1_d;
            bus.done_0   <= done_0_d;
            bus.done_1   <= done_1_d;
            bus.err      <= err_d;
            bus.mem_req  <= mem_req_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=16).
// Output vector packing used in checks: {sel, mem_req, err, done_1, done_0, gnt_1, gnt_0}.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare, count, report
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, bus.sel, bus.mem_req, bus.err, bus.done_1, bus.done_0, bus.gnt_1, bus.gnt_0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] exp_busy;
        logic [31:0] exp_done;
        logic [31:0] exp_idle;

        vecs = 0;
        errs = 0;
        rst_n       = 1'b0;
        bus.req_0   = 1'b0;
        bus.req_1   = 1'b0;
        bus.addr_0  = 32'h0;
        bus.addr_1  = 32'h0000_0200;
        bus.wdata_0 = 32'h0;
        bus.wdata_1 = 32'h1234_5678;
        bus.we_0    = 1'b0;
        bus.we_1    = 1'b0;
        bus.mem_ack = 1'b0;

        // Reset state
        #1;
        check("reset_outs", outs(), 32'h00);
        check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
        #11;
        rst_n = 1'b1;

        // Single write from requester 0, ack in first BUSY cycle
        bus.req_0   = 1'b1;
        bus.addr_0  = 32'h0000_0010;
        bus.we_0    = 1'b1;
        bus.wdata_0 = 32'hDEAD_BEEF;
        step();
        check("single_busy", outs(), 32'b0100001);
        check("single_addr", bus.mem_addr, 32'h0000_0010);
        check("single_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("single_we", {31'd0, bus.mem_we}, 32'd1);
        bus.mem_ack = 1'b1;
        bus.req_0   = 1'b0;
        step();
        check("single_done", outs(), 32'b0000100);
        check("single_we_off", {31'd0, bus.mem_we}, 32'd0);
        bus.mem_ack = 1'b0;
        step();
        check("single_idle", outs(), 32'b0000000);

        // Stray ack in IDLE
        bus.mem_ack = 1'b1;
        step();
        check("stray_ack_0", outs(), 32'b0000000);
        step();
        check("stray_ack_1", outs(), 32'b0000000);
        bus.mem_ack = 1'b0;

        // Tie after reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req_0   = 1'b1;
        bus.req_1   = 1'b1;
        bus.we_0    = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_busy = (i % 2 == 1) ? 32'b1100010 : 32'b0100001;
            exp_done = (i % 2 == 1) ? 32'b1001000 : 32'b0000100;
            exp_idle = (i % 2 == 1) ? 32'b1000000 : 32'b0000000;
            step();
            check($sformatf("tie_busy_%0d", i), outs(), exp_busy);
            step();
            check($sformatf("tie_done_%0d", i), outs(), exp_done);
            step();
            check($sformatf("tie_idle_%0d", i), outs(), exp_idle);
        end
        check("tie_addr_sel1", bus.mem_addr, 32'h0000_0200);
        bus.req_0   = 1'b0;
        bus.req_1   = 1'b0;
        bus.mem_ack = 1'b0;

        // Timeout on requester 1: mem_req high exactly 16 cycles
        bus.req_1 = 1'b1;
        step();
        check("to_busy", outs(), 32'b1100010);
        bus.req_1 = 1'b0;
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step();
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_done", outs(), 32'b1011000);
        step();
        check("to_idle", outs(), 32'b1000000);

        // Ack collides with timeout in 16th BUSY cycle; requester 1 held off meanwhile
        bus.req_0 = 1'b1;
        step();
        check("col_busy", outs(), 32'b0100001);
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b1;
        for (int k = 1; k < 16; k++) begin
            step();
        end
        check("col_busy16", outs(), 32'b0100001);
        bus.mem_ack = 1'b1;
        step();
        check("col_done", outs(), 32'b0000100);
        bus.mem_ack = 1'b0;
        step();
        check("holdoff_idle", outs(), 32'b0000000);
        step();
        check("holdoff_grant", outs(), 32'b1100010);
        bus.req_1   = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        check("holdoff_done", outs(), 32'b1001000);
        bus.mem_ack = 1'b0;
        step();
        check("holdoff_end", outs(), 32'b1000000);

        // Reset in 3rd BUSY cycle
        bus.req_0 = 1'b1;
        step();
        bus.req_0 = 1'b0;
        step();
        step();
        check("rst_busy3", outs(), 32'b0100001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 32'b0000000);
        step();
        check("rst_held", outs(), 32'b0000000);
        #2;
        rst_n = 1'b1;
        bus.req_0   = 1'b1;
        bus.req_1   = 1'b1;
        bus.mem_ack = 1'b1;
        step();
        check("rst_tie_gnt0", outs(), 32'b0100001);
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        step();
        check("rst_tie_done", outs(), 32'b0000100);
        bus.mem_ack = 1'b0;
        step();
        check("rst_tie_idle", outs(), 32'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
